// File: rtl/ahb_lite_master_arb.sv
// Round-robin arbiter feeding a single-transfer AHB-Lite master: one NONSEQ SINGLE
// address phase followed by one data phase per granted request.
module ahb_lite_master_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int RW   = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*3-1:0] req_size,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              hsel,
    output logic [AW-1:0]     haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [DW-1:0]     hwdata,
    input  logic [DW-1:0]     hrdata,
    input  logic              hready,
    input  logic [RW-1:0]     hresp
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   winner;
    logic [NREQ-1:0] grant_vec;
    logic            grant;

    // Search from last_grant+1 upward with wrap; iterating downward lets the
    // nearest valid requester be the final assignment.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] pick;
        int            cand;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (valid[IW'(cand)]) pick = IW'(cand);
        end
        return pick;
    endfunction

    assign winner    = rr_pick(req_valid, last_grant);
    assign grant_vec = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    assign req_ready = grant ? grant_vec : '0;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                // Gated by resetn so no accept pulse leaks out while reset is held.
                if (resetn && |req_valid) begin
                    grant     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR:    if (hready) state_nxt = DATA;
            DATA:    if (hready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            idx        <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hsize      <= '0;
            hwdata     <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            if (grant) begin
                last_grant <= winner;
                idx        <= winner;
                haddr      <= req_addr[winner*AW +: AW];
                hwrite     <= req_write[winner];
                hsize      <= req_size[winner*3 +: 3];
                hwdata     <= req_wdata[winner*DW +: DW];
            end
            if (state == DATA && hready) begin
                rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << idx;
                rsp_rdata <= hrdata;
                rsp_err   <= |hresp;
            end
        end
    end

    assign hsel   = (state == ADDR);
    assign htrans = (state == ADDR) ? 2'b10 : 2'b00;
    assign hburst = 3'b000;
    assign hprot  = 4'b0011;

endmodule

// File: doc/ahb_lite_master_arb.md
# ahb_lite_master_arb

Round-robin arbiter and single-transfer AHB-Lite master sequencer that shares one AHB-Lite slave port (hsel/haddr/htrans/hwrite/hsize/hburst/hprot/hwdata out; hrdata/hready/hresp in) between NREQ simple request/response clients. It sits between testbench or SoC requesters and the AHB-Lite slave, and issues one non-pipelined SINGLE transfer at a time: an address phase followed by a data phase.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- RW, 1, hresp width

Ports (flattened vectors are requester-major, requester i at [i*W +: W]):
- clk  input  1  bus clock
- resetn  input  1  reset; one clock, reset is asynchronous and active-low
- req_valid  input  NREQ  request pending per requester
- req_addr  input  NREQ*AW  transfer address
- req_write  input  NREQ  1 = write
- req_size  input  NREQ*3  hsize encoding
- req_wdata  input  NREQ*DW  write data
- req_ready  output  NREQ  one-hot accept pulse
- rsp_valid  output  NREQ  one-hot completion pulse
- rsp_rdata  output  DW  read data, valid with rsp_valid
- rsp_err  output  1  error response, valid with rsp_valid
- hsel  output  1  slave select
- haddr  output  AW  address
- htrans  output  2  transfer type
- hwrite  output  1  direction
- hsize  output  3  size
- hburst  output  3  burst type, constant 3'b000 (SINGLE)
- hprot  output  4  protection, constant 4'b0011
- hwdata  output  DW  write data
- hrdata  input  DW  read data
- hready  input  1  transfer done / phase advance
- hresp  input  RW  0 = OKAY, nonzero = ERROR

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any req_valid, grant winner combinationally. req_ready[winner]=1 this cycle. Latch addr/write/size/wdata and index. Go to ADDR. Otherwise stay in IDLE.
- Round-robin: priority starts at (last_grant+1) mod NREQ and wraps. last_grant updates on grant. Reset last_grant = NREQ-1, so requester 0 wins first.
- ADDR: hsel=1, htrans=2'b10 (NONSEQ), haddr/hwrite/hsize from latch. If hready=0, stay (address phase extended). If hready=1, go to DATA.
- DATA: htrans=2'b00, hsel=0, hwdata=latched wdata. If hready=0, wait. This includes the first ERROR cycle, where hresp≠0 and hready=0. If hready=1, capture hrdata into rsp_rdata and (hresp≠0) into rsp_err, pulse rsp_valid[index] next cycle, and go to IDLE.
- Outside ADDR: htrans=2'b00 and hsel=0. haddr/hwrite/hsize/hwdata hold their last value.
- A requester holds its req fields stable until req_ready. Dropping req_valid before grant is legal and has no effect.
- rsp_rdata and rsp_err hold until the next completion. rsp_rdata is captured for writes too; clients ignore it.

## Timing
- Reset (async assert, sync deassert via clk): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, hsel=0, haddr=0, htrans=2'b00, hwrite=0, hsize=0, hwdata=0, last_grant=NREQ-1.
- Best case with no wait states, grant in cycle 0: ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3. The next grant can occur in cycle 3.
- Each hready=0 cycle in ADDR or DATA adds one cycle.
- req_ready and rsp_valid are single-cycle pulses. At most one bit is set.
- Reset mid-transfer: the transfer is abandoned and no rsp_valid is issued. The requester must re-request.
- Requests arriving while not in IDLE wait. Grant is evaluated only in IDLE.

## Test plan
- Req0 write, addr 0x100, wdata 0xDEADBEEF, size 3'b010, hready=1 → cycle0 req_ready=2'b01; cycle1 htrans=2'b10, haddr=0x100, hwrite=1; cycle2 htrans=2'b00, hwdata=0xDEADBEEF; cycle3 rsp_valid=2'b01, rsp_err=0.
- Req1 read, addr 0x204, slave hready=0 for 2 DATA cycles then hrdata=0xCAFEF00D → rsp_valid=2'b10 five cycles after grant, rsp_rdata=0xCAFEF00D.
- Both req_valid held for 4 transfers from reset → grants in order 0,1,0,1. Each req_ready precedes its rsp_valid.
- hready=0 during ADDR for 3 cycles → htrans=2'b10 and haddr held stable all 4 cycles; DATA is entered only after hready=1.
- ERROR: hresp=1 with hready=0, then hresp=1 with hready=1 → rsp_err=1 on rsp_valid. FSM returns to IDLE, and the next transfer shows rsp_err=0.
- resetn asserted low in DATA → outputs immediately at reset values, no rsp_valid. After release, req0 wins first.
